// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the sequential multiply/divide unit: the operation
// encodings seen on the op input, the control FSM state encoding, the
// iteration count of the shift-add / restoring-divide loop, and small
// decode helpers so every user of the op field interprets it identically.
package muldiv_pkg;

  // Number of CALC cycles: one multiplier bit or one quotient bit per cycle
  localparam int ITER = 32;

  // Operation encodings (bit 0 clear selects the signed variant)
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  // Divide ops are the only ones that run the restoring-divide datapath
  function automatic logic isDivOp(op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // Signed ops take magnitudes of the operands and correct sign at the end
  function automatic logic isSignedOp(op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative MIPS-style HI/LO multiply/divide unit. One 64-bit shift register
// serves both the radix-2 shift-add multiplier and the restoring divider, so
// an operation takes 32 CALC cycles plus one FIN cycle. Operands are reduced
// to magnitudes on accept and the sign is fixed up in FIN, where HI/LO are
// written (optionally accumulating into the previous HI/LO).
//
// Ports
//   clock    in   sole clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   begin an operation (sampled only in IDLE)
//   op[2:0]  in   operation select, see muldiv_pkg::op_e
//   a,b      in   rs / rt operands, captured on the accepting edge
//   wr_hi    in   mthi strobe, data on a (IDLE only)
//   wr_lo    in   mtlo strobe, data on a (IDLE only)
//   rd_hilo  in   mfhi/mflo pending in the current instruction
//   hi,lo    out  architectural HI/LO registers
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  one-cycle pulse after HI/LO have been updated
//   stall    out  busy & (start | rd_hilo | wr_hi | wr_lo)
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic        rd_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  state_e      state_q,   state_d;
  op_e         op_q,      op_d;
  logic        negRes_q,  negRes_d;
  logic        negRem_q,  negRem_d;
  logic [31:0] operand_q, operand_d;
  logic [63:0] shift_q,   shift_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;
  logic        done_q,    done_d;

  op_e         opIn;
  logic        negA, negB;
  logic [31:0] magA, magB;
  logic [64:0] shifted;
  logic [32:0] top, diff;
  logic [31:0] addend;
  logic [32:0] sum;
  logic [31:0] quo, rem;
  logic [63:0] prod, acc, res;

  // State register bank. Reset discards any operation in flight and clears
  // the architectural HI/LO as well as all working registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      operand_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      operand_q <= operand_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic for the FSM and the shared datapath.
  // IDLE: apply mthi/mtlo, and on start load magnitudes into the shift
  //   register (multiplier or dividend in the low half) and operand_q
  //   (multiplicand or divisor).
  // CALC: one shift-add or restoring-divide step per cycle.
  // FIN: sign-correct, optionally accumulate, and write HI/LO.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    operand_d = operand_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    opIn    = op_e'(op);
    negA    = isSignedOp(opIn) & a[31];
    negB    = isSignedOp(opIn) & b[31];
    magA    = negA ? (32'd0 - a) : a;
    magB    = negB ? (32'd0 - b) : b;

    shifted = {shift_q, 1'b0};
    top     = shifted[64:32];
    diff    = top - {1'b0, operand_q};
    addend  = shift_q[0] ? operand_q : 32'd0;
    sum     = {1'b0, shift_q[63:32]} + {1'b0, addend};

    quo     = shift_q[31:0];
    rem     = shift_q[63:32];
    prod    = negRes_q ? (64'd0 - shift_q) : shift_q;
    acc     = {hi_q, lo_q};
    res     = prod;

    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = a;
        if (wr_lo) lo_d = a;
        if (start) begin
          state_d  = S_CALC;
          op_d     = opIn;
          negRes_d = negA ^ negB;
          negRem_d = negA;
          cnt_d    = '0;
          if (isDivOp(opIn)) begin
            operand_d = magB;
            shift_d   = {32'd0, magA};
          end else begin
            operand_d = magA;
            shift_d   = {32'd0, magB};
          end
        end
      end

      S_CALC: begin
        // Divide by zero falls out naturally: every trial subtraction
        // succeeds, giving an all-ones quotient and remainder = dividend.
        if (isDivOp(op_q)) begin
          if (top >= {1'b0, operand_q})
            shift_d = {diff[31:0], shifted[31:1], 1'b1};
          else
            shift_d = shifted[63:0];
        end else begin
          shift_d = {sum, shift_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_FIN;
      end

      S_FIN: begin
        if (isDivOp(op_q)) begin
          lo_d = negRes_q ? (32'd0 - quo) : quo;
          hi_d = negRem_q ? (32'd0 - rem) : rem;
        end else begin
          case (op_q)
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            default:           res = prod;
          endcase
          {hi_d, lo_d} = res;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3, operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-005 SHALL have ports a and b, input, 32 each, rs and rt operands; captured on the accepting edge.
REQ-006 SHALL have port wr_hi, input, 1, mthi write strobe; data on a.
REQ-007 SHALL have port wr_lo, input, 1, mtlo write strobe; data on a.
REQ-008 SHALL have port rd_hilo, input, 1, mfhi or mflo pending in the current instruction.
REQ-009 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.
REQ-010 SHALL have port busy, output, 1, high when not in IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after HI/LO update.
REQ-012 SHALL have port stall, output, 1, combinational: busy & (start | rd_hilo | wr_hi | wr_lo).

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE; start in IDLE moves to CALC at that edge.
REQ-014 SHALL on accept latch op, latch sign flags (signed ops only), latch |a| and |b| (raw values for unsigned ops), and clear the 5-bit iteration counter.
REQ-015 SHALL run exactly 32 CALC cycles.
- Multiply: radix-2 shift-add, 64-bit product.
- Divide: restoring, one quotient bit per cycle.
- After counter = 31, go to FIN.
REQ-016 SHALL in FIN apply sign correction and write HI/LO, then return to IDLE; done is high for the cycle after the FIN edge.
- Product: negated if sign(a) != sign(b).
- Quotient: negated if sign(a) != sign(b).
- Remainder: takes sign of a.
REQ-017 SHALL write results as follows.
- MULT/MULTU: {HI,LO} = product.
- DIV/DIVU: LO = quotient, HI = remainder.
- MADD(U): {HI,LO} = {HI,LO} + product, modulo 2^64.
- MSUB(U): {HI,LO} = {HI,LO} - product, modulo 2^64.
- Accumulate uses HI/LO as held at the FIN edge.
REQ-018 SHALL give fixed latency: busy high 33 cycles; results visible the cycle after edge N+33 when accepted at edge N.
REQ-019 SHALL handle divide by zero as follows.
- Unsigned: LO = 0xFFFFFFFF, HI = a.
- Signed: LO = 0x00000001 if a < 0 else 0xFFFFFFFF; HI = a.
- No exception.
REQ-020 SHALL return LO = 0x80000000, HI = 0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-021 SHALL ignore start, wr_hi and wr_lo while busy (stall asserted; requester holds).
REQ-022 SHALL in IDLE apply wr_hi/wr_lo at the edge; simultaneous start is also accepted, and accumulate ops then see the written values.
REQ-023 SHALL keep hi/lo stable during CALC (intermediate values in separate registers).

Reset
REQ-024 SHALL on reset, at any time including mid-CALC or FIN, force IDLE, hi = lo = 0, busy = done = 0, counter = 0, and discard the operation.
REQ-025 SHALL accept start on the first edge after reset deasserts.

Structure
REQ-026 SHALL place op encodings, FSM state encoding and ITER = 32 in shared package muldiv_pkg, also used by the control unit.
REQ-027 SHALL be a single module; a sub-module is not natural (shared 64-bit shift register serves both algorithms).

Verification
REQ-028 SHALL cover: MULT a=0xFFFFFFFD, b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy 33 cycles; done one pulse.
REQ-029 SHALL cover: DIVU a=100, b=7 -> LO=14, HI=2; DIV a=0xFFFFFFF9, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 SHALL cover: DIV a=5, b=0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 SHALL cover: wr_hi a=0 and wr_lo a=0xFFFFFFFF in IDLE, then MADDU a=1, b=1 -> HI=1, LO=0; MSUBU a=1, b=1 -> HI=0, LO=0xFFFFFFFF.
REQ-032 SHALL cover: rd_hilo or start asserted during CALC -> stall=1, operation unaffected; stall=0 once IDLE.
REQ-033 SHALL cover: reset asserted in CALC cycle 10 -> busy=0, hi=lo=0 immediately; subsequent MULTU 3*4 -> LO=12, HI=0.
